output_buffer: RTL and testbench
================================

OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning sample width in bits (signed, two's complement).
REQ-002 SHALL have parameter DEPTH, default 16, meaning storage entries; legal values are powers of two, 4..256.
REQ-003 SHALL have parameter AF_LEVEL, default 12, meaning the almost_full threshold; legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-006 SHALL have port valid_in, input, 1 bit, meaning a decimated sample is present this cycle; there is no backpressure to the upstream filter chain.
REQ-007 SHALL have port data_in, input, DATA_WIDTH bits, meaning the sample qualified by valid_in.
REQ-008 SHALL have port flush, input, 1 bit, meaning discard all stored samples.
REQ-009 SHALL have port clear_drop, input, 1 bit, meaning clear the drop flag and the drop counter.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts out_data this cycle.
REQ-011 SHALL have port out_valid, output, 1 bit, meaning out_data holds the oldest stored sample.
REQ-012 SHALL have port out_data, output, DATA_WIDTH bits, meaning the oldest stored sample.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1 bits, meaning the current occupancy.
REQ-014 SHALL have port almost_full, output, 1 bit, meaning level >= AF_LEVEL.
REQ-015 SHALL have port drop, output, 1 bit, meaning sticky: at least one sample was lost to a full buffer.
REQ-016 SHALL have port drop_cnt, output, 8 bits, meaning a saturating count of lost samples.

Function
REQ-017 SHALL store samples in arrival order in a circular buffer addressed by write/read pointers that wrap modulo DEPTH.
REQ-018 SHALL treat a push as valid_in=1 and a pop as out_valid=1 and out_ready=1 in the same cycle.
REQ-019 SHALL drive out_valid as (level != 0) and out_data as mem[rd_ptr], first-word-fall-through.
REQ-020 SHALL make a sample pushed into an empty buffer at edge N visible on out_valid/out_data after edge N, giving 1-cycle latency.
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL update level as follows: push only -> +1; pop only -> -1; push and pop together -> unchanged.
REQ-023 SHALL, when full (level=DEPTH) with a simultaneous pop, accept the push and leave level at DEPTH.
REQ-024 SHALL, when full without a pop, drop the push, leave the memory and pointers unchanged, set drop, and increment drop_cnt, saturating at 255.
REQ-025 SHALL, when empty, allow no pop; a push in that cycle makes level 1.
REQ-026 SHALL, on flush, zero both pointers and level, ignore any push or pop in the same cycle, and leave drop and drop_cnt unchanged.
REQ-027 SHALL, on clear_drop, zero drop and drop_cnt; if a drop occurs in the same cycle, leave drop=1 and drop_cnt=1.
REQ-028 SHALL register almost_full together with level so that both reflect the post-edge occupancy.
REQ-029 SHALL give rst priority over flush, clear_drop, push and pop.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set pointers=0, level=0, out_valid=0, almost_full=0, drop=0 and drop_cnt=0.
REQ-031 SHALL leave memory contents uninitialised at reset; out_data is don't-care while out_valid=0.
REQ-032 SHALL, when reset is asserted mid-operation, discard all stored samples; the first push after rst deasserts behaves as a push into an empty buffer.

Verification (DEPTH=16, AF_LEVEL=12)
REQ-033 SHALL cover: push 0x0001..0x0005 with out_ready=0 -> level=5, out_data=0x0001; then out_ready=1 for 5 cycles -> 0x0001..0x0005 in order, then out_valid=0.
REQ-034 SHALL cover: push 20 samples with out_ready=0 -> level=16, drop=1, drop_cnt=4, almost_full=1 from the 12th push, and the first 16 samples are read back intact.
REQ-035 SHALL cover: fill to 16, then push and pop together for 40 cycles -> level stays 16, drop=0, output order preserved across pointer wrap.
REQ-036 SHALL cover: 300 pushes while full -> drop_cnt=255; then clear_drop together with one further overflowing push -> drop=1, drop_cnt=1.
REQ-037 SHALL cover: level=7, then flush together with a push -> level=0 and out_valid=0 on the next cycle, and drop is unchanged.
REQ-038 SHALL cover: level=9, then rst pulsed for 1 cycle during a push -> all outputs at reset values; the next push gives level=1 with that sample on out_data.

Source files
------------

// File: rtl/output_buffer.sv
// output_buffer: first-word-fall-through circular sample buffer with overflow drop tracking.
module output_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       flush,
    input  logic                       clear_drop,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       drop,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] next_level;
    logic pop, full, accept, lost;
    assign out_valid = level != '0;
    assign out_data = mem[rd_ptr];
    assign pop = out_valid && out_ready;
    assign full = level == (AW+1)'(DEPTH);
    // a full buffer still takes a push when a pop frees a slot in the same cycle
    assign accept = valid_in && (!full || pop);
    assign lost = valid_in && full && !pop && !flush;
    always_comb begin
        next_level = flush ? '0 : level + (AW+1)'(accept) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (!rst && !flush && accept)
            mem[wr_ptr] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            drop        <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
            level       <= next_level;
            almost_full <= next_level >= (AW+1)'(AF_LEVEL);
            if (clear_drop) begin
                drop     <= lost;
                drop_cnt <= {7'd0, lost};
            end else if (lost) begin
                drop     <= 1'b1;
                drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hff};
            end
        end
    end
endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer: directed and random stimulus checked against a queue-based reference model.
module tb_output_buffer;
    logic clk = 1'b0;
    logic rst, valid_in, flush, clear_drop, out_ready;
    logic [15:0] data_in;
    logic out_valid, almost_full, drop;
    logic [15:0] out_data;
    logic [4:0] level;
    logic [7:0] drop_cnt;
    int checks = 0;
    int errors = 0;
    int q[$];
    bit mdrop;
    int mcnt;

    output_buffer #(.DATA_WIDTH(16), .DEPTH(16), .AF_LEVEL(12)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .flush(flush), .clear_drop(clear_drop), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .level(level),
        .almost_full(almost_full), .drop(drop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [15:0] d, input bit rdy,
                       input bit fl = 0, input bit cd = 0, input bit rs = 0);
        bit lost;
        rst = rs; valid_in = v; data_in = d; out_ready = rdy; flush = fl; clear_drop = cd;
        @(posedge clk);
        if (rs) begin
            q.delete(); mdrop = 0; mcnt = 0;
        end else begin
            lost = 0;
            if (fl) q.delete();
            else begin
                lost = v && q.size() == 16 && !(rdy && q.size() > 0);
                if (rdy && q.size() > 0) void'(q.pop_front());
                if (v && !lost) q.push_back(int'(d));
            end
            if (cd) begin
                mdrop = lost; mcnt = lost ? 1 : 0;
            end else if (lost) begin
                mdrop = 1; if (mcnt < 255) mcnt++;
            end
        end
        #1;
        check("out_valid", out_valid, q.size() != 0);
        check("level", level, q.size());
        check("almost_full", almost_full, q.size() >= 12);
        check("drop", drop, mdrop);
        check("drop_cnt", drop_cnt, mcnt);
        if (q.size() != 0) check("out_data", out_data, q[0]);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        check("reset_level", level, 0);
        check("reset_valid", out_valid, 0);
        // five pushes held, then drained in order
        for (int i = 1; i <= 5; i++) cyc(1, 16'(i), 0);
        check("r33_level", level, 5);
        check("r33_head", out_data, 16'h0001);
        for (int i = 1; i <= 5; i++) begin
            check("r33_order", out_data, i);
            cyc(0, 0, 1);
        end
        check("r33_empty", out_valid, 0);
        // overflow by four
        for (int i = 0; i < 20; i++) begin
            cyc(1, 16'($urandom), 0);
            if (i == 10) check("r34_af_low", almost_full, 0);
            if (i == 11) check("r34_af_12", almost_full, 1);
        end
        check("r34_level", level, 16);
        check("r34_drop", drop, 1);
        check("r34_cnt", drop_cnt, 4);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("r34_cleared", drop, 0);
        // full streaming across pointer wrap
        for (int i = 0; i < 16; i++) cyc(1, 16'($urandom), 0);
        for (int i = 0; i < 40; i++) cyc(1, 16'($urandom), 1);
        check("r35_level", level, 16);
        check("r35_drop", drop, 0);
        // saturation, then clear with a simultaneous drop
        for (int i = 0; i < 300; i++) cyc(1, 16'($urandom), 0);
        check("r36_sat", drop_cnt, 255);
        cyc(1, 16'h5a5a, 0, 0, 1);
        check("r36_drop", drop, 1);
        check("r36_cnt", drop_cnt, 1);
        // flush with a push
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 16'($urandom), 0);
        check("r37_pre", level, 7);
        cyc(1, 16'hbeef, 0, 1);
        check("r37_level", level, 0);
        check("r37_valid", out_valid, 0);
        check("r37_drop", drop, 1);
        // reset during a push
        for (int i = 0; i < 9; i++) cyc(1, 16'($urandom), 0);
        check("r38_pre", level, 9);
        cyc(1, 16'h7777, 0, 0, 0, 1);
        check("r38_level", level, 0);
        check("r38_drop", drop, 0);
        check("r38_cnt", drop_cnt, 0);
        check("r38_af", almost_full, 0);
        cyc(1, 16'h1234, 0);
        check("r38_push_level", level, 1);
        check("r38_push_data", out_data, 16'h1234);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(99) < 70, 16'($urandom), $urandom_range(1),
                $urandom_range(63) == 0, $urandom_range(63) == 0, $urandom_range(255) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
